// File: rtl/chord_mix_pkg.sv
// Shared constants, increment table and FSM state type for the chord voice mixer.
// Octave-10 increments assume a 48 kHz sample rate and a 24-bit phase accumulator.
package chord_mix_pkg;

    localparam int VOICES  = 16;
    localparam int NOTE_W  = 7;
    localparam int PHASE_W = 24;
    localparam int SAMPLE_W = 16;
    localparam int WAVE_W  = 12;

    // Index is the semitone within the octave (0 = C); lower octaves shift right.
    localparam logic [PHASE_W-1:0] BASE_INC [0:11] = '{
        24'd2926235, 24'd3100235, 24'd3284585, 24'd3479896,
        24'd3686822, 24'd3906052, 24'd4138318, 24'd4384395,
        24'd4645104, 24'd4921317, 24'd5213953, 24'd5523991
    };

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } mix_state_t;

endpackage

// File: rtl/note_to_inc.sv
// Combinational note number to per-sample phase increment.
// Octave and semitone come from a restoring compare-subtract chain (96, 48, 24, 12).
module note_to_inc
    import chord_mix_pkg::*;
(
    input  logic [NOTE_W-1:0]  note,
    output logic [PHASE_W-1:0] inc
);

    logic [NOTE_W-1:0] rem [0:4];
    logic [3:0]        oct;
    logic [3:0]        semi;
    logic [3:0]        shift;

    assign rem[0] = note;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_div
            localparam logic [NOTE_W-1:0] DIVISOR = NOTE_W'(12 << (3 - gi));
            assign oct[3-gi]  = (rem[gi] >= DIVISOR);
            assign rem[gi+1]  = oct[3-gi] ? (rem[gi] - DIVISOR) : rem[gi];
        end
    endgenerate

    // Remainder is always below 12, so the low four bits hold the semitone.
    assign semi  = rem[4][3:0];
    assign shift = 4'd10 - oct;
    assign inc   = BASE_INC[semi] >> shift;

endmodule

// File: rtl/chord_voice_mixer.sv
// Latches 16 chord notes and, on each sample tick, sweeps 16 phase accumulators into one summed sample.
// Build option: define CHORD_MIX_SQUARE_EN for square-wave voices instead of sawtooth.
module chord_voice_mixer
    import chord_mix_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [VOICES*NOTE_W-1:0]   notes,
    input  logic                       note_load,
    input  logic                       sample_tick,
    output logic [SAMPLE_W-1:0]        sample,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       overrun
);

    mix_state_t                  state_reg, state_next;
    logic [3:0]                  idx_reg, idx_next;
    logic [VOICES*NOTE_W-1:0]    shadow_reg, shadow_next;
    logic [VOICES*NOTE_W-1:0]    active_reg, active_next;
    logic signed [SAMPLE_W-1:0]  sum_reg, sum_next;
    logic [SAMPLE_W-1:0]         sample_reg, sample_next;
    logic                        valid_reg, valid_next;
    logic                        overrun_reg, overrun_next;
    logic [PHASE_W-1:0]          phase_reg [VOICES];

    logic [NOTE_W-1:0]           cur_note;
    logic [PHASE_W-1:0]          cur_inc;
    logic [PHASE_W-1:0]          new_phase;
    logic signed [WAVE_W-1:0]    wave;
    logic signed [SAMPLE_W-1:0]  wave_ext;
    logic                        phase_we;

    assign cur_note  = active_reg[idx_reg*NOTE_W +: NOTE_W];
    assign new_phase = phase_reg[idx_reg] + cur_inc;

    note_to_inc u_note_to_inc (
        .note (cur_note),
        .inc  (cur_inc)
    );

`ifdef CHORD_MIX_SQUARE_EN
    assign wave = new_phase[PHASE_W-1] ? -12'sd1024 : 12'sd1023;
`else
    assign wave = new_phase[PHASE_W-1 -: WAVE_W];
`endif

    assign wave_ext = {{(SAMPLE_W-WAVE_W){wave[WAVE_W-1]}}, wave};

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        sum_next     = sum_reg;
        active_next  = active_reg;
        shadow_next  = note_load ? notes : shadow_reg;
        sample_next  = sample_reg;
        valid_next   = 1'b0;
        overrun_next = sample_tick && (state_reg != IDLE);
        phase_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sample_tick) begin
                    // A load coinciding with the tick takes effect in this frame.
                    active_next = note_load ? notes : shadow_reg;
                    sum_next    = '0;
                    idx_next    = '0;
                    state_next  = ACC;
                end
            end
            ACC: begin
                if (cur_note != '0) begin
                    phase_we = 1'b1;
                    sum_next = sum_reg + wave_ext;
                end
                idx_next = 4'(idx_reg + 4'd1);
                if (idx_reg == 4'd15) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                sample_next = sum_reg;
                valid_next  = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            shadow_reg  <= '0;
            active_reg  <= '0;
            sum_reg     <= '0;
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            shadow_reg  <= shadow_next;
            active_reg  <= active_next;
            sum_reg     <= sum_next;
            sample_reg  <= sample_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_reg[i] <= '0;
            end
        end else if (phase_we) begin
            phase_reg[idx_reg] <= new_phase;
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign overrun      = overrun_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_chord_voice_mixer.sv
// Directed bench for chord_voice_mixer: latency, mixing values, overrun, note-load timing, mid-frame reset.
// Expected samples are hand-computed for both the sawtooth and the CHORD_MIX_SQUARE_EN build.
module tb_chord_voice_mixer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [111:0] notes = '0;
    logic         note_load = 1'b0;
    logic         sample_tick = 1'b0;
    logic [15:0]  sample;
    logic         sample_valid;
    logic         busy;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CHORD_MIX_SQUARE_EN
    localparam int EXP_C9    = 1023;
    localparam int EXP_V3_1  = 1023;
    localparam int EXP_V3_2  = 1023;
    localparam int EXP_LOAD2 = 2046;
    localparam int EXP_ALL [6] = '{16368, 16368, -16384, -16384, -16384, 16368};
`else
    localparam int EXP_C9    = 714;
    localparam int EXP_V3_1  = 22;
    localparam int EXP_V3_2  = 44;
    localparam int EXP_LOAD2 = 44;
    localparam int EXP_ALL [6] = '{11424, 22848, -31248, -19824, -8384, 3040};
`endif

    always #5 clk = ~clk;

    chord_voice_mixer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .notes        (notes),
        .note_load    (note_load),
        .sample_tick  (sample_tick),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic logic [111:0] pack_note(input int voice, input int note);
        logic [111:0] v;
        v = '0;
        v[voice*7 +: 7] = 7'(note);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_notes(input logic [111:0] val);
        @(negedge clk);
        notes     = val;
        note_load = 1'b1;
        @(negedge clk);
        note_load = 1'b0;
    endtask

    // load_at: -1 none, 0 together with the tick, k>0 sampled at edge Ek of the frame.
    task automatic run_frame(input string tag, input int load_at,
                             input logic [111:0] load_val, output int smp);
        int k;
        @(negedge clk);
        sample_tick = 1'b1;
        if (load_at == 0) begin
            notes     = load_val;
            note_load = 1'b1;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        note_load   = 1'b0;
        k = 0;
        check_eq({tag, "_busy_after_tick"}, int'(busy), 1);
        while (!sample_valid && k < 40) begin
            note_load = (k == load_at - 1);
            if (k == load_at - 1) notes = load_val;
            @(negedge clk);
            k++;
        end
        note_load = 1'b0;
        check_eq({tag, "_latency"}, k, 17);
        smp = int'($signed(sample));
        check_eq({tag, "_busy_drop"}, int'(busy), 0);
        @(negedge clk);
        check_eq({tag, "_valid_pulse"}, int'(sample_valid), 0);
    endtask

    task automatic tick_pair(input int spacing, output int valids, output int overruns);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        valids   = int'(sample_valid);
        overruns = int'(overrun);
        for (int k = 0; k < 45; k++) begin
            sample_tick = (k == spacing - 1);
            @(negedge clk);
            if (sample_valid) valids++;
            if (overrun) overruns++;
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        int smp;
        int nv;
        int no;
        logic [111:0] all_c9;
        logic [111:0] pair_c4;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("reset_sample", int'(sample), 0);
        check_eq("reset_valid", int'(sample_valid), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_overrun", int'(overrun), 0);

        run_frame("silent", -1, '0, smp);
        check_eq("silent_sample", smp, 0);

        // Silent frame must not have advanced phase 0.
        load_notes(pack_note(0, 120));
        run_frame("c9", -1, '0, smp);
        check_eq("c9_sample", smp, EXP_C9);

        do_reset();
        load_notes(pack_note(3, 60));
        run_frame("c4_1", -1, '0, smp);
        check_eq("c4_sample1", smp, EXP_V3_1);
        run_frame("c4_2", -1, '0, smp);
        check_eq("c4_sample2", smp, EXP_V3_2);

        do_reset();
        all_c9 = '0;
        for (int v = 0; v < 16; v++) all_c9 |= pack_note(v, 120);
        load_notes(all_c9);
        for (int t = 0; t < 6; t++) begin
            run_frame($sformatf("all_%0d", t), -1, '0, smp);
            check_eq($sformatf("all_sample_%0d", t), smp, EXP_ALL[t]);
        end

        tick_pair(10, nv, no);
        check_eq("sp10_overrun", no, 1);
        check_eq("sp10_valids", nv, 1);
        tick_pair(17, nv, no);
        check_eq("sp17_overrun", no, 1);
        check_eq("sp17_valids", nv, 1);
        tick_pair(18, nv, no);
        check_eq("sp18_overrun", no, 0);
        check_eq("sp18_valids", nv, 2);

        do_reset();
        load_notes(pack_note(0, 120));
        pair_c4 = pack_note(1, 60) | pack_note(2, 60);
        run_frame("ld_e5", 5, pair_c4, smp);
        check_eq("ld_e5_old_notes", smp, EXP_C9);
        run_frame("ld_next", -1, '0, smp);
        check_eq("ld_next_new_notes", smp, EXP_LOAD2);

        do_reset();
        run_frame("bypass", 0, pack_note(0, 120), smp);
        check_eq("bypass_sample", smp, EXP_C9);

        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        nv = 0;
        for (int k = 0; k < 30; k++) begin
            reset_n = !(k >= 7 && k < 9);
            @(negedge clk);
            if (sample_valid) nv++;
        end
        reset_n = 1'b1;
        check_eq("abort_valids", nv, 0);
        check_eq("abort_sample", int'(sample), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_overrun", int'(overrun), 0);
        run_frame("after_abort", -1, '0, smp);
        check_eq("after_abort_sample", smp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
